router_rr_arbiter: RTL and testbench
====================================

# router_rr_arbiter

Round-robin packet arbiter that shares one 4-way address router among four requesters. Each requester presents data beats with a 2-bit destination address and a last-beat flag. The arbiter grants one requester at a time and holds the grant for a whole packet. Granted beats pass through a single registered output stage that drives four destination ports; the idle ports carry zero.

## Interface
- DATA_WIDTH, 32, width of one data beat
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  4  per-requester beat valid; bit i belongs to requester i
- req_data  in  4*DATA_WIDTH  requester i beat at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_addr  in  8  requester i destination port at bits [2*i +: 2]
- req_last  in  4  per-requester last-beat-of-packet flag
- req_ready  out  4  beat i is accepted on a cycle where req_valid[i] && req_ready[i]
- dout0..dout3  out  DATA_WIDTH each  destination port data; zero when that port is not valid
- dout_valid  out  4  per-destination beat valid
- dout_ready  in  4  per-destination sink ready
- busy  out  1  high while a multi-beat packet holds the grant (state LOCKED)

## Operation
- State: state ∈ {IDLE, LOCKED}, owner[1:0], port_lock[1:0], rr_ptr[1:0], and an output stage made of out_vld, out_port[1:0] and out_data.
- can_accept = !out_vld || dout_ready[out_port]. A beat held at the output drains and a new beat loads in the same cycle.
- IDLE:
  - pick = first i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod 4.
  - req_ready[pick] = can_accept. All other bits are 0.
  - If no requester is valid, req_ready = 0.
- LOCKED: req_ready[owner] = can_accept. All other bits are 0. Other requesters are never served mid-packet.
- Accept, in IDLE, of beat from pick:
  - Destination is req_addr of that beat.
  - If req_last = 1: rr_ptr ← pick+1 mod 4, and the state stays IDLE.
  - Else: owner ← pick, port_lock ← req_addr, and the state goes to LOCKED.
- Accept, in LOCKED, of beat from owner:
  - Destination is port_lock. The req_addr of non-head beats is ignored.
  - If req_last = 1: rr_ptr ← owner+1 mod 4, and the state goes to IDLE.
- On any accept: out_vld ← 1, out_port ← destination, out_data ← beat.
- Drain without accept: out_vld ← 0 when dout_ready[out_port] = 1.
- Outputs:
  - dout_valid[p] = out_vld && out_port == p (one-hot or zero).
  - dout_p = dout_valid[p] ? out_data : 0.
  - busy = (state == LOCKED).
- rr_ptr advances only at packet end, never on an idle cycle.

## Timing
- Reset: state = IDLE, rr_ptr = 0, owner = 0, port_lock = 0, out_vld = 0. This gives dout_valid = 0, dout0..3 = 0 and busy = 0. req_ready is 0 in the first post-reset cycle unless a requester is valid; can_accept is 1.
- req_ready is combinational from req_valid, state, out_vld and dout_ready. There is no combinational path from req_data to the outputs.
- Latency: beat accepted on edge N is visible on dout/dout_valid from edge N until it drains.
- Throughput: 1 beat/cycle while the destination holds dout_ready high. There are no bubbles between packets of different requesters.
- Backpressure: while out_vld && !dout_ready[out_port], the output stage and all outputs hold stable and req_ready = 0.
- The dout_ready bits of other ports are ignored.
- A reset asserted mid-packet wins over everything: it returns to IDLE, sets rr_ptr to 0 and drops any held beat.
- A requester deasserting req_valid mid-packet keeps LOCKED and the grant; there is no timeout.

## Test plan
- Reset, then hold all inputs at 0 for 3 cycles → dout0..3 = 0, dout_valid = 4'b0000, req_ready = 0, busy = 0.
- Requester 2 sends a single beat with data 0xDEADBEEF, addr 1, last 1, with dout_ready = 4'hF → req_ready = 4'b0100 in that cycle; next cycle dout1 = 0xDEADBEEF, dout_valid = 4'b0010, dout0/2/3 = 0.
- All four requesters hold single-beat packets continuously from reset → accepts occur in order 0,1,2,3,0 on consecutive cycles with no idle cycle.
- rr_ptr = 0, requesters 1 and 3 valid. Requester 1 sends 3 beats (A,B,C) with head addr 3, later beats addr 0, last on C → busy = 1 after A; dout3 carries A,B,C back-to-back with nothing on dout0; requester 3 is served only after C; busy = 0 after C.
- A beat is held on port 0 with dout_ready[0] = 0 for 4 cycles while requester 1 is valid → dout0 stable, req_ready = 0. Raise dout_ready[0] → the held beat drains and requester 1's beat loads in the same cycle.
- Assert reset on the second beat of a 4-beat packet → the next cycle shows IDLE, busy = 0, dout_valid = 0. After reset, with requesters 0 and 2 valid, requester 0 is granted first.

Source files
------------

// File: rtl/router_rr_arbiter.sv
// router_rr_arbiter
// Round-robin packet arbiter in front of a 4-way address router. Four
// requesters offer beats carrying a 2-bit destination and a last flag. One
// requester holds the grant for a whole packet. Accepted beats land in a
// single registered output stage that drives one of four destination ports.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   req_valid[3:0]      : per-requester beat valid
//   req_data            : requester i beat at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_addr[7:0]       : requester i destination at [2*i +: 2]
//   req_last[3:0]       : per-requester last-beat flag
//   req_ready[3:0]      : combinational grant/accept qualifier
//   dout0..dout3        : destination port data, zero when not valid
//   dout_valid[3:0]     : per-destination beat valid (one-hot or zero)
//   dout_ready[3:0]     : per-destination sink ready
//   busy                : a multi-beat packet holds the grant
module router_rr_arbiter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                req_valid,
    input  logic [4*DATA_WIDTH-1:0]   req_data,
    input  logic [7:0]                req_addr,
    input  logic [3:0]                req_last,
    output logic [3:0]                req_ready,
    output logic [DATA_WIDTH-1:0]     dout0,
    output logic [DATA_WIDTH-1:0]     dout1,
    output logic [DATA_WIDTH-1:0]     dout2,
    output logic [DATA_WIDTH-1:0]     dout3,
    output logic [3:0]                dout_valid,
    input  logic [3:0]                dout_ready,
    output logic                      busy
);

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Registered state
    logic [0:0]            state_q,     state_d;
    logic [IDX_W-1:0]      owner_q,     owner_d;
    logic [IDX_W-1:0]      port_lock_q, port_lock_d;
    logic [IDX_W-1:0]      rr_ptr_q,    rr_ptr_d;
    logic                  out_vld_q,   out_vld_d;
    logic [IDX_W-1:0]      out_port_q,  out_port_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;

    // Per-requester lane views of the flattened buses
    logic [DATA_WIDTH-1:0] lane_data [NUM_REQ];
    logic [IDX_W-1:0]      lane_addr [NUM_REQ];

    logic                  can_accept;
    logic [IDX_W-1:0]      pick;
    logic                  pick_valid;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_en;
    logic [3:0]            ready_c;
    logic                  accept;
    logic                  beat_last;
    logic [IDX_W-1:0]      beat_addr;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [IDX_W-1:0]      dest;

    // Split flattened request buses into lanes
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lane_data[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            lane_addr[i] = req_addr[i*IDX_W +: IDX_W];
        end
    end

    // Output stage can take a beat if empty or draining this cycle
    assign can_accept = !out_vld_q || dout_ready[out_port_q];

    // Round-robin pick: first valid requester at rr_ptr, rr_ptr+1, ...
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        logic [IDX_W-1:0] idx;
        pick       = '0;
        pick_valid = 1'b0;
        idx        = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = rr_ptr_q + IDX_W'(k);
            if (req_valid[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

    // Grant selection: owner while locked, round-robin pick otherwise
    always_comb begin
        grant_idx = (state_q == ST_LOCKED) ? owner_q : pick;
        grant_en  = (state_q == ST_LOCKED) || pick_valid;
    end

    // Combinational ready toward the requesters
    always_comb begin
        ready_c = '0;
        if (grant_en && can_accept) begin
            ready_c[grant_idx] = 1'b1;
        end
    end

    assign req_ready = ready_c;

    // Beat currently offered by the granted requester
    always_comb begin
        accept    = req_valid[grant_idx] && ready_c[grant_idx];
        beat_last = req_last[grant_idx];
        beat_addr = lane_addr[grant_idx];
        beat_data = lane_data[grant_idx];
        // Non-head beats follow the port locked by the packet head
        dest      = (state_q == ST_LOCKED) ? port_lock_q : beat_addr;
    end

    // Next-state logic for the grant FSM and output stage
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        port_lock_d = port_lock_q;
        rr_ptr_d    = rr_ptr_q;
        out_vld_d   = out_vld_q;
        out_port_d  = out_port_q;
        out_data_d  = out_data_q;

        if (accept) begin
            out_vld_d  = 1'b1;
            out_port_d = dest;
            out_data_d = beat_data;
            case (state_q)
                ST_IDLE: begin
                    if (beat_last) begin
                        rr_ptr_d = pick + IDX_W'(1);
                    end else begin
                        owner_d     = pick;
                        port_lock_d = beat_addr;
                        state_d     = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (beat_last) begin
                        rr_ptr_d = owner_q + IDX_W'(1);
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (out_vld_q && dout_ready[out_port_q]) begin
            out_vld_d = 1'b0;
        end
    end

    // State register; reset drops any held beat and restarts the rotation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            port_lock_q <= '0;
            rr_ptr_q    <= '0;
            out_vld_q   <= 1'b0;
            out_port_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            port_lock_q <= port_lock_d;
            rr_ptr_q    <= rr_ptr_d;
            out_vld_q   <= out_vld_d;
            out_port_q  <= out_port_d;
            out_data_q  <= out_data_d;
        end
    end

    // Destination decode from the registered output stage
    always_comb begin
        dout_valid = '0;
        if (out_vld_q) begin
            dout_valid[out_port_q] = 1'b1;
        end
    end

    assign dout0 = dout_valid[0] ? out_data_q : '0;
    assign dout1 = dout_valid[1] ? out_data_q : '0;
    assign dout2 = dout_valid[2] ? out_data_q : '0;
    assign dout3 = dout_valid[3] ? out_data_q : '0;

    assign busy = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_router_rr_arbiter.sv
// tb_router_rr_arbiter
// Directed bench for router_rr_arbiter: reset, single beat, round-robin
// rotation, packet locking, backpressure and mid-packet reset.
module tb_router_rr_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [7:0]   req_addr;
    logic [3:0]   req_last;
    logic [3:0]   req_ready;
    logic [31:0]  dout0, dout1, dout2, dout3;
    logic [3:0]   dout_valid;
    logic [3:0]   dout_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    router_rr_arbiter #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_addr   (req_addr),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .dout0      (dout0),
        .dout1      (dout1),
        .dout2      (dout2),
        .dout3      (dout3),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check all four ports against an expected valid vector and data
    task automatic chk_outs(input string tag, input logic [3:0] exp_vld, input logic [31:0] exp_data);
        chk4({tag, ".dout_valid"}, dout_valid, exp_vld);
        chk32({tag, ".dout0"}, dout0, exp_vld[0] ? exp_data : 32'h0);
        chk32({tag, ".dout1"}, dout1, exp_vld[1] ? exp_data : 32'h0);
        chk32({tag, ".dout2"}, dout2, exp_vld[2] ? exp_data : 32'h0);
        chk32({tag, ".dout3"}, dout3, exp_vld[3] ? exp_data : 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [31:0] d);
        req_data[i*32 +: 32] = d;
    endtask

    task automatic clear_reqs();
        req_valid = 4'b0;
        req_data  = '0;
        req_addr  = 8'h0;
        req_last  = 4'b0;
    endtask

    initial begin
        reset      = 1'b1;
        dout_ready = 4'h0;
        clear_reqs();
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset
        for (int c = 0; c < 3; c++) tick();
        chk_outs("reset", 4'b0000, 32'h0);
        chk4("reset.req_ready", req_ready, 4'b0000);
        chk1("reset.busy", busy, 1'b0);

        // Single beat from requester 2 to port 1
        dout_ready = 4'hF;
        req_valid  = 4'b0100;
        set_lane(2, 32'hDEADBEEF);
        req_addr   = 8'h10;
        req_last   = 4'b0100;
        #1;
        chk4("single.req_ready", req_ready, 4'b0100);
        tick();
        clear_reqs();
        chk_outs("single", 4'b0010, 32'hDEADBEEF);
        chk1("single.busy", busy, 1'b0);
        tick();
        chk_outs("single.drain", 4'b0000, 32'h0);

        // All four hold single-beat packets from reset: rotation 0,1,2,3,0
        reset     = 1'b1;
        req_valid = 4'hF;
        req_last  = 4'hF;
        req_addr  = 8'hE4;
        for (int i = 0; i < 4; i++) set_lane(i, 32'h10000000 + 32'(i));
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk4($sformatf("rr%0d.req_ready", k), req_ready, 4'(1 << (k % 4)));
            tick();
            chk_outs($sformatf("rr%0d", k), 4'(1 << (k % 4)), 32'h10000000 + 32'(k % 4));
        end

        // Packet lock: rr_ptr=0, requesters 1 and 3 valid
        reset = 1'b1;
        clear_reqs();
        tick();
        reset     = 1'b0;
        req_valid = 4'b1010;
        set_lane(1, 32'hAAAA0001);
        set_lane(3, 32'h33330003);
        req_addr  = 8'h8C;
        req_last  = 4'b1000;
        #1;
        chk4("pktA.req_ready", req_ready, 4'b0010);
        tick();
        chk1("pktA.busy", busy, 1'b1);
        chk_outs("pktA", 4'b1000, 32'hAAAA0001);
        set_lane(1, 32'hAAAA0002);
        req_addr = 8'h80;
        #1;
        chk4("pktB.req_ready", req_ready, 4'b0010);
        tick();
        chk1("pktB.busy", busy, 1'b1);
        chk_outs("pktB", 4'b1000, 32'hAAAA0002);
        set_lane(1, 32'hAAAA0003);
        req_last = 4'b1010;
        #1;
        chk4("pktC.req_ready", req_ready, 4'b0010);
        tick();
        chk1("pktC.busy", busy, 1'b0);
        chk_outs("pktC", 4'b1000, 32'hAAAA0003);
        req_valid = 4'b1000;
        #1;
        chk4("pkt3.req_ready", req_ready, 4'b1000);
        tick();
        chk_outs("pkt3", 4'b0100, 32'h33330003);
        clear_reqs();
        tick();
        chk_outs("pkt.drain", 4'b0000, 32'h0);

        // Backpressure on port 0 (rr_ptr now 0)
        dout_ready = 4'b1110;
        req_valid  = 4'b0001;
        set_lane(0, 32'h5A5A0000);
        req_addr   = 8'h00;
        req_last   = 4'b0001;
        tick();
        chk_outs("bp.load", 4'b0001, 32'h5A5A0000);
        clear_reqs();
        req_valid = 4'b0010;
        set_lane(1, 32'h11110001);
        req_addr  = 8'h08;
        req_last  = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk4($sformatf("bp%0d.req_ready", c), req_ready, 4'b0000);
            tick();
            chk_outs($sformatf("bp%0d", c), 4'b0001, 32'h5A5A0000);
        end
        dout_ready = 4'hF;
        #1;
        chk4("bp.release.req_ready", req_ready, 4'b0010);
        tick();
        chk_outs("bp.release", 4'b0100, 32'h11110001);
        clear_reqs();
        tick();

        // Reset on the second beat of a 4-beat packet (rr_ptr now 2)
        req_valid = 4'b0100;
        set_lane(2, 32'h00000020);
        req_addr  = 8'h10;
        req_last  = 4'b0000;
        tick();
        chk1("rst.beat1.busy", busy, 1'b1);
        chk_outs("rst.beat1", 4'b0010, 32'h00000020);
        set_lane(2, 32'h00000021);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("rst.busy", busy, 1'b0);
        chk4("rst.dout_valid", dout_valid, 4'b0000);
        clear_reqs();
        req_valid = 4'b0101;
        set_lane(0, 32'h00C0FFEE);
        set_lane(2, 32'h00000002);
        req_last  = 4'b0101;
        #1;
        chk4("rst.after.req_ready", req_ready, 4'b0001);
        tick();
        chk_outs("rst.after", 4'b0001, 32'h00C0FFEE);
        clear_reqs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
